xor_result_checker: RTL and testbench

//   Receive end of the XOR stimulus path: samples operand/result vectors presented
//   to the XOR datapath, recomputes expected A^B, and scores the DUT result.

---
 rtl/xor_result_checker.sv | 88 ++++++++
 tb/tb_xor_result_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_result_checker.sv
// On-chip self-test monitor for the XOR datapath: recomputes A^B for each presented
// vector, scores the DUT result, and reports pass/fail after a fixed-length run.
module xor_result_checker #(
    parameter int WIDTH       = 1,
    parameter int NUM_VECTORS = 4,
    parameter int COUNT_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] vector_count,
    output logic [COUNT_W-1:0] error_count,
    output logic               first_fail_valid,
    output logic [COUNT_W-1:0] first_fail_index
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(NUM_VECTORS - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    state_t state;
    logic   mismatch;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    assign mismatch = (in_c != (in_a ^ in_b));
    assign pass     = done && (error_count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            vector_count     <= '0;
            error_count      <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A vector arriving alongside start is deliberately dropped.
                    if (start) begin
                        state            <= RUN;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        vector_count     <= '0;
                        error_count      <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_index <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        vector_count <= vector_count + COUNT_W'(1);
                        if (mismatch) begin
                            error_count <= sat_inc(error_count);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_index <= vector_count;
                            end
                        end
                        if (vector_count == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_result_checker.sv
// Directed bench for xor_result_checker: three parameterisations share clock and reset,
// vectors are driven on the falling edge and outputs checked on the next falling edge.
module tb_xor_result_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance 0: WIDTH=1, NUM_VECTORS=4, COUNT_W=8
    logic       st0, v0, a0, b0, c0, busy0, done0, pass0, ffv0;
    logic [7:0] vc0, ec0, ffi0;
    xor_result_checker #(.WIDTH(1), .NUM_VECTORS(4), .COUNT_W(8)) u0 (
        .clock(clk), .reset(rst), .start(st0), .in_valid(v0),
        .in_a(a0), .in_b(b0), .in_c(c0),
        .busy(busy0), .done(done0), .pass(pass0),
        .vector_count(vc0), .error_count(ec0),
        .first_fail_valid(ffv0), .first_fail_index(ffi0));

    // Instance 1: WIDTH=1, NUM_VECTORS=3, COUNT_W=2
    logic       st1, v1, a1, b1, c1, busy1, done1, pass1, ffv1;
    logic [1:0] vc1, ec1, ffi1;
    xor_result_checker #(.WIDTH(1), .NUM_VECTORS(3), .COUNT_W(2)) u1 (
        .clock(clk), .reset(rst), .start(st1), .in_valid(v1),
        .in_a(a1), .in_b(b1), .in_c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .vector_count(vc1), .error_count(ec1),
        .first_fail_valid(ffv1), .first_fail_index(ffi1));

    // Instance 2: WIDTH=8, NUM_VECTORS=2, COUNT_W=8
    logic       st2, v2, busy2, done2, pass2, ffv2;
    logic [7:0] a2, b2, c2, vc2, ec2, ffi2;
    xor_result_checker #(.WIDTH(8), .NUM_VECTORS(2), .COUNT_W(8)) u2 (
        .clock(clk), .reset(rst), .start(st2), .in_valid(v2),
        .in_a(a2), .in_b(b2), .in_c(c2),
        .busy(busy2), .done(done2), .pass(pass2),
        .vector_count(vc2), .error_count(ec2),
        .first_fail_valid(ffv2), .first_fail_index(ffi2));

    typedef struct {
        logic a, b, c;
        int   vc, ec, ffv, ffi, dn, ps;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // All drive tasks are entered and left on a falling edge.
    task automatic start0();
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
    endtask

    task automatic vec0(input logic a, input logic b, input logic c);
        a0 = a; b0 = b; c0 = c; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic vec1(input logic a, input logic b, input logic c);
        a1 = a; b1 = b; c1 = c; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic vec2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        a2 = a; b2 = b; c2 = c; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic chk0(input string nm, input int vc, input int ec, input int ffv,
                        input int ffi, input int dn, input int ps, input int bz);
        chk({nm, ".vector_count"}, int'(vc0), vc);
        chk({nm, ".error_count"}, int'(ec0), ec);
        chk({nm, ".first_fail_valid"}, int'(ffv0), ffv);
        chk({nm, ".first_fail_index"}, int'(ffi0), ffi);
        chk({nm, ".done"}, int'(done0), dn);
        chk({nm, ".pass"}, int'(pass0), ps);
        chk({nm, ".busy"}, int'(busy0), bz);
    endtask

    initial begin
        // Run 1 all good; run 2 with 3rd and 4th results wrong.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 3, 0, 0, 0, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 4, 0, 0, 0, 1, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2, 0, 0, 0, 0, 0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 3, 1, 1, 2, 0, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 4, 2, 1, 2, 1, 0};

        rst = 1'b1;
        {st0, v0, a0, b0, c0} = '0;
        {st1, v1, a1, b1, c1} = '0;
        {st2, v2} = '0; a2 = '0; b2 = '0; c2 = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        chk0("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.u1.busy", int'(busy1), 0);
        chk("reset.u2.done", int'(done2), 0);

        // Table-driven runs on instance 0.
        for (int r = 0; r < 2; r++) begin
            start0();
            chk("run.busy_after_start", int'(busy0), 1);
            for (int i = 0; i < 4; i++) begin
                vec_t t;
                t = tbl[r*4 + i];
                vec0(t.a, t.b, t.c);
                chk0($sformatf("tbl%0d", r*4 + i), t.vc, t.ec, t.ffv, t.ffi, t.dn, t.ps, t.dn ? 0 : 1);
            end
        end

        // Valid pulses in DONE must not disturb the held results.
        vec0(1'b0, 1'b0, 1'b1);
        vec0(1'b1, 1'b1, 1'b1);
        chk0("done_ignore", 4, 2, 1, 2, 1, 0, 0);

        // Gapped run, with ignored pulses in IDLE first.
        rst = 1'b1; #1; rst = 1'b0;
        vec0(1'b1, 1'b1, 1'b1);
        chk0("idle_ignore", 0, 0, 0, 0, 0, 0, 0);
        start0();
        begin
            int gaps[4] = '{0, 2, 5, 1};
            for (int i = 0; i < 4; i++) begin
                idle(gaps[i]);
                chk($sformatf("gap%0d.vector_count_hold", i), int'(vc0), i);
                vec0(tbl[i].a, tbl[i].b, tbl[i].c);
            end
        end
        chk0("gapped", 4, 0, 0, 0, 1, 1, 0);
        vec0(1'b0, 1'b1, 1'b0);
        chk0("gapped_after", 4, 0, 0, 0, 1, 1, 0);

        // Asynchronous reset mid-run.
        start0();
        vec0(1'b0, 1'b0, 1'b1);
        vec0(1'b0, 1'b1, 1'b1);
        chk("midrun.vector_count", int'(vc0), 2);
        rst = 1'b1;
        #1;
        chk0("async_reset", 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        start0();
        for (int i = 0; i < 4; i++) vec0(tbl[i].a, tbl[i].b, tbl[i].c);
        chk0("after_reset_run", 4, 0, 0, 0, 1, 1, 0);

        // Instance 1: small counters, every vector wrong, start ignored in RUN.
        st1 = 1'b1; @(negedge clk); st1 = 1'b0;
        vec1(1'b0, 1'b0, 1'b1);
        chk("u1.ec1", int'(ec1), 1);
        chk("u1.ffi", int'(ffi1), 0);
        st1 = 1'b1; @(negedge clk); st1 = 1'b0;
        chk("u1.start_in_run.vc", int'(vc1), 1);
        vec1(1'b1, 1'b0, 1'b0);
        chk("u1.ec2", int'(ec1), 2);
        vec1(1'b1, 1'b1, 1'b1);
        chk("u1.ec3", int'(ec1), 3);
        chk("u1.vc3", int'(vc1), 3);
        chk("u1.done", int'(done1), 1);
        chk("u1.pass", int'(pass1), 0);
        chk("u1.ffi_held", int'(ffi1), 0);
        // Start with a vector in the same DONE cycle: vector dropped.
        st1 = 1'b1;
        vec1(1'b0, 1'b0, 1'b1);
        st1 = 1'b0;
        chk("u1.restart.busy", int'(busy1), 1);
        chk("u1.restart.vc", int'(vc1), 0);
        chk("u1.restart.ec", int'(ec1), 0);
        chk("u1.restart.ffv", int'(ffv1), 0);
        vec1(1'b1, 1'b0, 1'b1);
        chk("u1.restart.vc1", int'(vc1), 1);
        chk("u1.restart.ec1", int'(ec1), 0);

        // Instance 2: 8-bit operands, single-bit error detection.
        st2 = 1'b1; @(negedge clk); st2 = 1'b0;
        vec2(8'hA5, 8'h0F, 8'hAA);
        chk("u2.good.ec", int'(ec2), 0);
        vec2(8'hA5, 8'h0F, 8'hAB);
        chk("u2.bad.ec", int'(ec2), 1);
        chk("u2.bad.ffi", int'(ffi2), 1);
        chk("u2.bad.pass", int'(pass2), 0);
        chk("u2.bad.done", int'(done2), 1);
        st2 = 1'b1; @(negedge clk); st2 = 1'b0;
        vec2(8'hA5, 8'h0F, 8'hAA);
        vec2(8'h3C, 8'hFF, 8'hC3);
        chk("u2.allgood.pass", int'(pass2), 1);
        chk("u2.allgood.vc", int'(vc2), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
